timer_alarm_ctrl: RTL
=====================

TIMER_ALARM_CTRL -- requirements
Module: timer_alarm_ctrl

Interface
REQ-001 Parameter BASE_ADDR, default 32'hFFFF_F100, byte base address of the register window.
REQ-002 Parameter NSLOT, default 4, number of alarm slots; the supported range is 1..4.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset; asynchronous assertion and active-low.
REQ-005 tim_count  input  32  free-running count from the system timer.
REQ-006 wen  input  1  bus write strobe; one write per cycle.
REQ-007 addr  input  32  bus byte address.
REQ-008 wdata  input  32  bus write data.
REQ-009 rdata  output  32  registered read data for addr.
REQ-010 irq  output  1  registered level interrupt to the CPU.

Function
REQ-011 Register map (offset from BASE_ADDR) SHALL be:
- 0x00+8*i: CMP_i, 32-bit compare value.
- 0x04+8*i: PER_i, 32-bit reload period; 0 means one-shot.
- 0x20: CTRL, where bits[3:0] are EN_i and bits[7:4] are IE_i.
- 0x24: PEND, bits[3:0]; reads return the pending bits, writes are write-1-to-clear.
- 0x28: IRQ_ID, read-only; bit31 is valid, bits[1:0] hold the lowest-index pending-and-enabled slot.
REQ-012 Writes to unmapped offsets, to IRQ_ID, or to slots i>=NSLOT SHALL be ignored; reads of them SHALL return 0.
REQ-013 rdata SHALL be updated every cycle with the value at addr as it stood before that edge's updates, giving 1-cycle read latency.
REQ-014 Each slot SHALL run a two-state FSM: IDLE (EN_i=0) and ARMED (EN_i=1).
REQ-015 In ARMED, when tim_count==CMP_i, the slot SHALL set PEND_i on that edge.
REQ-016 On a match with PER_i!=0, CMP_i SHALL become CMP_i+PER_i, wrapping modulo 2^32, and the slot SHALL stay ARMED.
REQ-017 On a match with PER_i==0, EN_i SHALL clear and the slot SHALL return to IDLE.
REQ-018 Because of REQ-016/REQ-017, a slot SHALL fire at most once per match even when tim_count holds the same value for many cycles.
REQ-019 A bus write of EN_i=1 SHALL arm the slot; matching SHALL begin on the following cycle.
REQ-020 A slot in IDLE SHALL never set PEND_i.
REQ-021 If a bus write to CMP_i or CTRL coincides with a match on slot i, the match SHALL still set PEND_i.
REQ-022 In that coincidence the bus-written CMP_i or EN_i value SHALL take priority over the hardware reload or clear.
REQ-023 A W1C to PEND_i in the same cycle as a new match on slot i SHALL leave PEND_i=1, because set wins.
REQ-024 irq SHALL be registered and equal OR(PEND_i & IE_i), lagging PEND by one cycle.
REQ-025 IRQ_ID SHALL be a fixed-priority encode of PEND & IE with slot 0 highest; bit31=0 and index 0 when none is pending.
REQ-026 Several slots matching on the same edge SHALL all set their PEND bits on that edge.

Reset
REQ-027 While rst_n=0, all CMP, PER, CTRL, PEND, rdata and irq SHALL be 0 and all slots SHALL be IDLE.
REQ-028 Reset asserted mid-operation SHALL abort immediately, with no pending interrupt surviving.
REQ-029 After rst_n deasserts, the first edge SHALL behave as normal operation.

Verification
REQ-030 One-shot:
- Stimulus: CMP_0=100, PER_0=0, CTRL=0x11, then ramp tim_count through 100 and hold it at 100 for 5 cycles.
- Required response: PEND=0x1 exactly once, irq=1 one cycle later, CTRL[0]=0, IRQ_ID=0x8000_0000.
REQ-031 Periodic:
- Stimulus: CMP_1=10, PER_1=10, EN_1 and IE_1 set, ramp tim_count 0..35.
- Required response: matches at 10, 20 and 30, CMP_1 reads 40, and each W1C of 0x2 drops irq until the next match.
REQ-032 Wrap-around:
- Stimulus: CMP_2=0xFFFF_FFF0, PER_2=0x20.
- Required response: fires at 0xFFFF_FFF0 and then CMP_2 reads 0x0000_0010.
REQ-033 Collisions:
- Stimulus: W1C PEND_0 on the match edge.
- Required response: PEND_0 stays 1.
- Stimulus: write CMP_0=500 on the match edge.
- Required response: CMP_0 reads 500 and PEND_0=1.
REQ-034 Priority:
- Stimulus: slots 1 and 3 match on the same edge with IE=0xA.
- Required response: PEND=0xA and IRQ_ID=0x8000_0001.
- Stimulus: clear PEND_1.
- Required response: IRQ_ID=0x8000_0003.
REQ-035 Reset:
- Stimulus: assert rst_n=0 while PEND=0xF and irq=1.
- Required response: irq, PEND, CTRL and rdata read 0 immediately, with no fire after release.

Source files
------------

// File: rtl/timer_alarm_ctrl.sv
// Memory-mapped alarm controller: up to four compare/reload slots that latch
// pending bits against the system timer and raise a registered level interrupt.
module timer_alarm_ctrl #(
  parameter logic [31:0] BASE_ADDR = 32'hFFFF_F100,
  parameter int          NSLOT     = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] tim_count,
  input  logic        wen,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_ARMED = 1'b1;

  localparam logic [3:0] WORD_CTRL   = 4'd8;
  localparam logic [3:0] WORD_PEND   = 4'd9;
  localparam logic [3:0] WORD_IRQ_ID = 4'd10;

  // Slots at or above NSLOT are never written and never match, so they stay 0.
  localparam logic [3:0] SLOT_MASK = 4'((32'd1 << NSLOT) - 32'd1);

  logic [31:0] r_cmp [4];
  logic [31:0] r_per [4];
  logic [3:0]  r_state;   // per-slot FSM state, also readable as CTRL.EN
  logic [3:0]  r_ie;
  logic [3:0]  r_pend;
  logic [31:0] r_rdata;
  logic        r_irq;

  logic [31:0] w_off;
  logic [3:0]  w_word;
  logic        w_hit;
  logic [3:0]  w_match;
  logic [31:0] w_cmp_nxt [4];
  logic [31:0] w_per_nxt [4];
  logic [3:0]  w_state_nxt;
  logic [3:0]  w_ie_nxt;
  logic [3:0]  w_pend_nxt;
  logic [3:0]  w_active;
  logic [1:0]  w_irq_id;
  logic [31:0] w_rd;

  assign w_off  = addr - BASE_ADDR;
  assign w_word = w_off[5:2];
  assign w_hit  = (w_off < 32'h0000_002C) && (w_off[1:0] == 2'b00);

  assign w_active = r_pend & r_ie;

  // NOTE: every combinational output gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_ie_nxt    = r_ie;
    w_pend_nxt  = r_pend;
    w_match     = '0;
    for (int i = 0; i < 4; i++) begin
      w_cmp_nxt[i] = r_cmp[i];
      w_per_nxt[i] = r_per[i];
      w_match[i]   = SLOT_MASK[i] && (r_state[i] == ST_ARMED) && (tim_count == r_cmp[i]);

      // Hardware reload/clear first; a same-cycle bus write below overrides it.
      if (w_match[i]) begin
        if (r_per[i] != 32'd0) w_cmp_nxt[i] = r_cmp[i] + r_per[i];
        else                   w_state_nxt[i] = ST_IDLE;
      end

      if (wen && w_hit && SLOT_MASK[i]) begin
        if (w_word == 4'(2 * i))     w_cmp_nxt[i] = wdata;
        if (w_word == 4'(2 * i + 1)) w_per_nxt[i] = wdata;
        if (w_word == WORD_CTRL) begin
          w_state_nxt[i] = wdata[i];
          w_ie_nxt[i]    = wdata[4 + i];
        end
        if (w_word == WORD_PEND && wdata[i]) w_pend_nxt[i] = 1'b0;
      end

      // Set wins over a coincident write-1-to-clear.
      if (w_match[i]) w_pend_nxt[i] = 1'b1;
    end
  end

  always_comb begin
    w_irq_id = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (w_active[i]) w_irq_id = 2'(i);
    end
  end

  always_comb begin
    w_rd = '0;
    if (w_hit) begin
      if (w_word < WORD_CTRL) begin
        w_rd = w_word[0] ? r_per[w_word[2:1]] : r_cmp[w_word[2:1]];
      end else if (w_word == WORD_CTRL) begin
        w_rd = {24'd0, r_ie, r_state};
      end else if (w_word == WORD_PEND) begin
        w_rd = {28'd0, r_pend};
      end else if (w_word == WORD_IRQ_ID) begin
        w_rd = {|w_active, 29'd0, w_irq_id};
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  // NOTE: the CMP/PER arrays are reset too; software may read them before
  // writing and expects 0, and reset must leave no slot able to fire.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        r_cmp[i] <= '0;
        r_per[i] <= '0;
      end
      r_state <= '0;
      r_ie    <= '0;
      r_pend  <= '0;
      r_rdata <= '0;
      r_irq   <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        r_cmp[i] <= w_cmp_nxt[i];
        r_per[i] <= w_per_nxt[i];
      end
      r_state <= w_state_nxt;
      r_ie    <= w_ie_nxt;
      r_pend  <= w_pend_nxt;
      r_rdata <= w_rd;
      r_irq   <= |w_active;
    end
  end

  assign rdata = r_rdata;
  assign irq   = r_irq;

endmodule
